// File: rtl/running_sum.sv
// Purpose: sliding-window (boxcar) sum of the last WINDOW samples, one add/subtract per clock.
// Latency: 2 edges sample-to-source (3 edges with RUNNING_SUM_MEAN_EN defined).
// Backpressure: none; sink is a continuous stream, one sample accepted every clock.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   clear        synchronous restart of the window fill, accumulator zeroed
//   sink         newest sample x_t
//   sink_old     x_(t-WINDOW), from a delay line with DELAY = WINDOW
//   source       window sum (OUT_WIDTH bits), or rounded mean (WIDTH bits) with the macro
//   source_valid high once source covers a full window
//
// Optional build macro: RUNNING_SUM_MEAN_EN -- output the mean rounded half-up through
// an extra register stage (WINDOW must then be a power of two).

module running_sum #(
    parameter  int WIDTH     = 16,
    parameter  int WINDOW    = 8,
    localparam int OUT_WIDTH = WIDTH + $clog2(WINDOW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     sink,
    input  logic [WIDTH-1:0]     sink_old,
`ifdef RUNNING_SUM_MEAN_EN
    output logic [WIDTH-1:0]     source,
`else
    output logic [OUT_WIDTH-1:0] source,
`endif
    output logic                 source_valid
);

    localparam int              CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    if (WINDOW < 2) begin : g_window_check
        $error("running_sum: WINDOW must be >= 2");
    end

    typedef enum logic {FILL, RUN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       sub_dat;
    logic                   win_full;

    logic signed [WIDTH:0]  diff_q;
    logic                   diff_vld;
    logic                   full_i_q;   // stage-I diff completes a full window
    logic                   full_ii_q;  // same flag aligned with acc_q
    logic [OUT_WIDTH-1:0]   acc_q;
    logic [OUT_WIDTH-1:0]   diff_ext;

    // Sign-extend the stage-I difference to the accumulator width.
    assign diff_ext = OUT_WIDTH'(diff_q);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While filling, the delay line holds stale data, so nothing is subtracted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sub_dat  = '0;
        win_full = 1'b0;
        case (state_q)
            FILL: begin
                if (cnt_q == LAST) begin
                    state_d  = RUN;
                    win_full = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                sub_dat  = sink_old;
                win_full = 1'b1;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Stage I: difference; stage II: accumulate. clear drops the in-flight diff.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            diff_q    <= '0;
            diff_vld  <= 1'b0;
            full_i_q  <= 1'b0;
            full_ii_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            diff_q    <= $signed({1'b0, sink}) - $signed({1'b0, sub_dat});
            diff_vld  <= 1'b1;
            full_i_q  <= win_full;
            full_ii_q <= full_i_q;
            if (diff_vld) begin
                acc_q <= acc_q + diff_ext;
            end
        end
    end

`ifdef RUNNING_SUM_MEAN_EN
    localparam int SH = $clog2(WINDOW);

    if ((1 << SH) != WINDOW) begin : g_pow2_check
        $error("running_sum: WINDOW must be a power of two for the mean output");
    end

    // acc + WINDOW/2 cannot overflow: WINDOW*(2^WIDTH-1) + WINDOW/2 < 2^OUT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            source       <= '0;
            source_valid <= 1'b0;
        end else begin
            source       <= WIDTH'((acc_q + OUT_WIDTH'(WINDOW / 2)) >> SH);
            source_valid <= full_ii_q;
        end
    end
`else
    assign source       = acc_q;
    assign source_valid = full_ii_q;
`endif

endmodule
